// File: rtl/pll_seq_pkg.sv
// Shared types and default timing constants for the PLL reset sequencer.
package pll_seq_pkg;

  typedef enum logic [1:0] {
    RESET     = 2'd0,
    WAIT_LOCK = 2'd1,
    QUALIFY   = 2'd2,
    RUN       = 2'd3
  } pll_seq_state_e;

  // Defaults sized for a 100 MHz reference.
  localparam int unsigned RST_HOLD_CYCLES_DEF     = 1000;
  localparam int unsigned LOCK_TIMEOUT_CYCLES_DEF = 100000;
  localparam int unsigned LOCK_STABLE_CYCLES_DEF  = 4096;
  localparam int unsigned CNT_W_DEF               = 8;

  // Largest of three cycle counts; sizes the shared sequencing counter.
  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchronizer, asynchronous active-low reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops to resolve metastability on an asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset / lock qualification sequencer on the free-running reference clock.
// Pulses pll_rst, waits for lock, debounces it, then releases sys_rst_n; loss of
// lock or force_relock re-runs the sequence.
// Optional build macro PLL_SEQ_STATUS_EN: builds relock_count and a dedicated
// lock_stable register; otherwise relock_count is 0 and lock_stable follows sys_rst_n.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES     = RST_HOLD_CYCLES_DEF,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_CYCLES_DEF,
  parameter int unsigned LOCK_STABLE_CYCLES  = LOCK_STABLE_CYCLES_DEF,
  parameter int unsigned CNT_W               = CNT_W_DEF
) (
  input  logic             refclk,
  input  logic             rst_n,
  input  logic             pll_locked,
  input  logic             force_relock,
  output logic             pll_rst,
  output logic             sys_rst_n,
  output logic             lock_stable,
  output logic [CNT_W-1:0] relock_count
);

  localparam int unsigned MAX_CYCLES =
    max3(RST_HOLD_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);
  localparam int unsigned CW = $clog2(MAX_CYCLES) + 1;

  pll_seq_state_e state, next_state;
  logic [CW-1:0]  cnt, cnt_next;
  logic           locked_s;
  logic           pll_rst_d, sys_rst_n_d;

  sync_2ff u_lock_sync (
    .clk   (refclk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // State and shared counter registers.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RESET;
      cnt   <= '0;
    end else begin
      state <= next_state;
      cnt   <= cnt_next;
    end
  end

  // Next-state, counter and output decode; force_relock outranks all other exits.
  always_comb begin
    next_state  = state;
    cnt_next    = cnt + CW'(1);
    pll_rst_d   = 1'b0;
    sys_rst_n_d = 1'b0;
    case (state)
      RESET: begin
        if (cnt == CW'(RST_HOLD_CYCLES - 1)) next_state = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (force_relock)                                next_state = RESET;
        else if (locked_s)                               next_state = QUALIFY;
        else if (cnt == CW'(LOCK_TIMEOUT_CYCLES - 1))    next_state = RESET;
      end
      QUALIFY: begin
        if (force_relock)                                next_state = RESET;
        else if (!locked_s)                              next_state = WAIT_LOCK;
        else if (cnt == CW'(LOCK_STABLE_CYCLES - 1))     next_state = RUN;
      end
      RUN: begin
        cnt_next = '0;
        if (force_relock || !locked_s) next_state = RESET;
      end
      default: next_state = RESET;
    endcase
    if (next_state != state) cnt_next = '0;
    pll_rst_d   = (next_state == RESET);
    sys_rst_n_d = (next_state == RUN);
  end

  // Output registers, loaded from the next-state decode so they track the state register.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
    end else begin
      pll_rst   <= pll_rst_d;
      sys_rst_n <= sys_rst_n_d;
    end
  end

`ifdef PLL_SEQ_STATUS_EN
  logic             relock_inc;
  logic [CNT_W-1:0] relock_q;
  logic             lock_stable_q;

  // Any exit into RESET is one retry, so simultaneous causes count once.
  assign relock_inc = (state != RESET) && (next_state == RESET);

  // Saturating retry counter and lock status register.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      relock_q      <= '0;
      lock_stable_q <= 1'b0;
    end else begin
      if (relock_inc && (relock_q != {CNT_W{1'b1}})) relock_q <= relock_q + CNT_W'(1);
      lock_stable_q <= sys_rst_n_d;
    end
  end

  assign relock_count = relock_q;
  assign lock_stable  = lock_stable_q;
`else
  assign relock_count = '0;
  assign lock_stable  = sys_rst_n;
`endif

endmodule
